ra_shadow_stack_ctrl: RTL and testbench

- Controller that sequences a hardware return-address shadow stack beside the branch unit.
- On every call (JAL/JALR with rd=x1) it pushes the plain, unencoded link address.
- On every return (JALR rd=x0, rs1=x1) it pops and compares against the decoded jump target.
- Any mismatch is flagged as a control-flow violation. The block owns stack storage, pointer management, overflow/underflow policy, flush sequencing and a sticky alarm state.

---
 rtl/ra_shadow_stack_ctrl_pkg.sv | 14 +
 rtl/ra_shadow_stack_ctrl_if.sv | 23 ++
 rtl/ss_lifo_mem.sv | 24 ++
 rtl/ra_shadow_stack_ctrl.sv | 167 ++++++++++++++++
 tb/tb_ra_shadow_stack_ctrl.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/ra_shadow_stack_ctrl_pkg.sv
// Shared types and defaults for the return-address shadow stack controller.
package ra_shadow_stack_ctrl_pkg;

    typedef enum logic [1:0] {
        SS_FLUSH,
        SS_RUN,
        SS_CHECK,
        SS_ALARM
    } ss_state_e;

    localparam int unsigned SS_DEPTH_DEFAULT = 8;
    localparam int unsigned SS_AW_DEFAULT    = 32;

endpackage

// File: rtl/ra_shadow_stack_ctrl_if.sv
// Call/return event channel between the branch unit (master) and the shadow stack (slave).
interface ra_shadow_stack_ctrl_if
    import ra_shadow_stack_ctrl_pkg::*;
#(
    parameter int unsigned AW = SS_AW_DEFAULT
);
    logic          call_valid_i;
    logic [AW-1:0] call_addr_i;
    logic          ret_valid_i;
    logic [AW-1:0] ret_target_i;
    logic          ready_o;
    logic          violation_o;

    modport master (
        output call_valid_i, call_addr_i, ret_valid_i, ret_target_i,
        input  ready_o, violation_o
    );

    modport slave (
        input  call_valid_i, call_addr_i, ret_valid_i, ret_target_i,
        output ready_o, violation_o
    );
endinterface

// File: rtl/ss_lifo_mem.sv
// Pointer-free DEPTH x AW storage: one write port, one combinational read port.
module ss_lifo_mem #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 32,
    localparam int unsigned PW   = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [PW-1:0] waddr_i,
    input  logic [AW-1:0] wdata_i,
    input  logic [PW-1:0] raddr_i,
    output logic [AW-1:0] rdata_o
);
    // Not reset: the controller's flush walk zeroes every entry.
    logic [AW-1:0] entry_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            entry_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = entry_q[raddr_i];
endmodule

// File: rtl/ra_shadow_stack_ctrl.sv
// Shadow stack controller: pushes link addresses on calls, checks return targets on returns.
module ra_shadow_stack_ctrl
    import ra_shadow_stack_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH                  = SS_DEPTH_DEFAULT,
    parameter int unsigned AW                     = SS_AW_DEFAULT,
    parameter bit          UNDERFLOW_IS_VIOLATION = 1'b1,
    localparam int unsigned PW                    = $clog2(DEPTH),
    localparam int unsigned CW                    = PW + 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   en_i,
    input  logic                   clear_i,
    input  logic                   flush_i,
    ra_shadow_stack_ctrl_if.slave  ev,
    output logic                   alarm_o,
    output logic [CW-1:0]          count_o,
    output logic                   lost_o,
    output logic [1:0]             led_o
);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_SLOT  = PW'(DEPTH - 1);

    ss_state_e     state_q, state_d;
    logic [PW-1:0] top_q, top_d;
    logic [PW-1:0] fcnt_q, fcnt_d;
    logic [CW-1:0] count_q, count_d;
    logic          lost_q, lost_d;
    logic          und_q, und_d;
    logic [AW-1:0] pop_data_q, pop_data_d;
    logic [AW-1:0] ret_tgt_q, ret_tgt_d;

    logic          mem_we;
    logic [PW-1:0] mem_waddr;
    logic [AW-1:0] mem_wdata;
    logic [PW-1:0] mem_raddr;
    logic [AW-1:0] mem_rdata;

    logic restart, accept, do_push, pop_req, do_pop, underflow, mismatch, empty, full;

    assign restart   = flush_i | clear_i;
    assign accept    = ev.ready_o & en_i & ~restart;
    assign do_push   = accept & ev.call_valid_i;
    assign pop_req   = accept & ev.ret_valid_i;
    assign empty     = (count_q == '0);
    assign full      = (count_q == FULL_COUNT);
    assign do_pop    = pop_req & ~empty;
    // An empty pop after lost entries is expected (the entry was discarded), so never flagged.
    assign underflow = pop_req & empty & ~lost_q & UNDERFLOW_IS_VIOLATION;
    assign mismatch  = (state_q == SS_CHECK) & (und_q | (pop_data_q != ret_tgt_q));
    assign mem_raddr = top_q - PW'(1);

    assign ev.ready_o     = (state_q == SS_RUN) || (state_q == SS_CHECK);
    assign ev.violation_o = mismatch & ~restart;
    assign alarm_o        = (state_q == SS_ALARM);
    assign count_o        = count_q;
    assign lost_o         = lost_q;
    assign led_o          = {alarm_o, lost_q};

    ss_lifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (mem_wdata),
        .raddr_i (mem_raddr),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        state_d    = state_q;
        top_d      = top_q;
        fcnt_d     = fcnt_q;
        count_d    = count_q;
        lost_d     = lost_q;
        und_d      = und_q;
        pop_data_d = pop_data_q;
        ret_tgt_d  = ret_tgt_q;
        mem_we     = 1'b0;
        mem_waddr  = top_q;
        mem_wdata  = ev.call_addr_i;

        if (restart) begin
            state_d = SS_FLUSH;
            fcnt_d  = '0;
        end else begin
            case (state_q)
                SS_FLUSH: begin
                    mem_we    = 1'b1;
                    mem_waddr = fcnt_q;
                    mem_wdata = '0;
                    fcnt_d    = fcnt_q + PW'(1);
                    if (fcnt_q == LAST_SLOT) begin
                        state_d = SS_RUN;
                        top_d   = '0;
                        count_d = '0;
                        lost_d  = 1'b0;
                    end
                end
                SS_RUN, SS_CHECK: begin
                    if (do_pop) begin
                        pop_data_d = mem_rdata;
                        ret_tgt_d  = ev.ret_target_i & ~AW'(1);
                        und_d      = 1'b0;
                    end
                    if (underflow) begin
                        und_d = 1'b1;
                    end
                    // A push alongside a pop reuses the slot the pop just freed.
                    if (do_push) begin
                        mem_we    = 1'b1;
                        mem_waddr = do_pop ? (top_q - PW'(1)) : top_q;
                    end
                    case ({do_push, do_pop})
                        2'b10: begin
                            top_d = top_q + PW'(1);
                            if (full) begin
                                lost_d = 1'b1;
                            end else begin
                                count_d = count_q + CW'(1);
                            end
                        end
                        2'b01: begin
                            top_d   = top_q - PW'(1);
                            count_d = count_q - CW'(1);
                        end
                        default: ;
                    endcase
                    if (mismatch) begin
                        state_d = SS_ALARM;
                    end else if (do_pop || underflow) begin
                        state_d = SS_CHECK;
                    end else begin
                        state_d = SS_RUN;
                    end
                end
                SS_ALARM: ;
                default: state_d = SS_FLUSH;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= SS_FLUSH;
            top_q      <= '0;
            fcnt_q     <= '0;
            count_q    <= '0;
            lost_q     <= 1'b0;
            und_q      <= 1'b0;
            pop_data_q <= '0;
            ret_tgt_q  <= '0;
        end else begin
            state_q    <= state_d;
            top_q      <= top_d;
            fcnt_q     <= fcnt_d;
            count_q    <= count_d;
            lost_q     <= lost_d;
            und_q      <= und_d;
            pop_data_q <= pop_data_d;
            ret_tgt_q  <= ret_tgt_d;
        end
    end
endmodule

// File: tb/tb_ra_shadow_stack_ctrl.sv
// Directed bench for ra_shadow_stack_ctrl with hand-computed expectations (DEPTH=8, AW=32).
module tb_ra_shadow_stack_ctrl;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 32;
    localparam int unsigned CW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          clear;
    logic          flush;
    logic          alarm;
    logic [CW-1:0] count;
    logic          lost;
    logic [1:0]    led;

    int total = 0;
    int bad   = 0;

    ra_shadow_stack_ctrl_if #(.AW(AW)) ev ();

    ra_shadow_stack_ctrl #(
        .DEPTH                  (DEPTH),
        .AW                     (AW),
        .UNDERFLOW_IS_VIOLATION (1'b1)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .en_i    (en),
        .clear_i (clear),
        .flush_i (flush),
        .ev      (ev),
        .alarm_o (alarm),
        .count_o (count),
        .lost_o  (lost),
        .led_o   (led)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [AW-1:0] addr);
        $display("push addr=%08h", addr);
        ev.call_valid_i = 1'b1;
        ev.call_addr_i  = addr;
        tick();
        ev.call_valid_i = 1'b0;
    endtask

    task automatic ret(input logic [AW-1:0] tgt);
        $display("ret  target=%08h en=%0b", tgt, en);
        ev.ret_valid_i  = 1'b1;
        ev.ret_target_i = tgt;
        tick();
        ev.ret_valid_i  = 1'b0;
    endtask

    task automatic flush_wait(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("%s_flush_ready%0d", tag, i), ev.ready_o, 0);
            tick();
        end
        chk($sformatf("%s_run_ready", tag), ev.ready_o, 1);
        chk($sformatf("%s_run_count", tag), count, 0);
        chk($sformatf("%s_run_lost", tag), lost, 0);
        $display("flush done (%s)", tag);
    endtask

    initial begin
        logic [AW-1:0] a [9];
        rst = 1'b1; en = 1'b1; clear = 1'b0; flush = 1'b0;
        ev.call_valid_i = 1'b0; ev.call_addr_i = '0;
        ev.ret_valid_i  = 1'b0; ev.ret_target_i = '0;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_ready", ev.ready_o, 0);
        chk("rst_viol", ev.violation_o, 0);
        chk("rst_alarm", alarm, 0);
        chk("rst_count", count, 0);
        chk("rst_lost", lost, 0);
        chk("rst_led", led, 0);
        flush_wait("init");

        // Matching call/return pair
        push(32'h8000_0104);
        chk("match_count1", count, 1);
        ret(32'h8000_0104);
        chk("match_viol", ev.violation_o, 0);
        chk("match_count0", count, 0);
        tick();
        chk("match_run_ready", ev.ready_o, 1);
        chk("match_alarm", alarm, 0);

        // Mismatching return -> violation one cycle later, then ALARM until clear
        push(32'h8000_0104);
        ev.ret_valid_i  = 1'b1;
        ev.ret_target_i = 32'h8000_0200;
        chk("mm_viol_early", ev.violation_o, 0);
        tick();
        ev.ret_valid_i = 1'b0;
        chk("mm_viol", ev.violation_o, 1);
        tick();
        chk("mm_alarm", alarm, 1);
        chk("mm_ready", ev.ready_o, 0);
        chk("mm_viol_once", ev.violation_o, 0);
        chk("mm_led", led, 2'b10);
        tick();
        chk("mm_alarm_held", alarm, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("mm_clear_alarm", alarm, 0);
        flush_wait("clear");

        // Return on an empty stack with nothing lost
        ret(32'h8000_0000);
        chk("und_viol", ev.violation_o, 1);
        tick();
        chk("und_alarm", alarm, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        flush_wait("und");

        // Overflow: 9 pushes into 8 entries, then 8 matching returns and one underflow
        for (int i = 0; i < 9; i++) a[i] = 32'h8000_1000 + 32'(4 * i);
        ev.call_valid_i = 1'b1;
        for (int i = 0; i < 9; i++) begin
            $display("push addr=%08h", a[i]);
            ev.call_addr_i = a[i];
            tick();
        end
        ev.call_valid_i = 1'b0;
        chk("ovf_count", count, 8);
        chk("ovf_lost", lost, 1);
        chk("ovf_led", led, 2'b01);
        ev.ret_valid_i = 1'b1;
        for (int k = 8; k >= 1; k--) begin
            $display("ret  target=%08h en=%0b", a[k], en);
            ev.ret_target_i = a[k];
            tick();
            chk($sformatf("ovf_pop%0d_viol", k), ev.violation_o, 0);
        end
        $display("ret  target=%08h en=%0b", 32'h1234_5678, en);
        ev.ret_target_i = 32'h1234_5678;
        tick();
        ev.ret_valid_i = 1'b0;
        chk("ovf_und_viol", ev.violation_o, 0);
        chk("ovf_und_count", count, 0);
        chk("ovf_und_lost", lost, 1);
        tick();
        chk("ovf_und_alarm", alarm, 0);
        chk("ovf_und_viol2", ev.violation_o, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        flush_wait("ovf");

        // Simultaneous call and return
        push(32'h8000_0104);
        $display("call+ret addr=%08h target=%08h", 32'h8000_0300, 32'h8000_0104);
        ev.call_valid_i  = 1'b1;
        ev.call_addr_i   = 32'h8000_0300;
        ev.ret_valid_i   = 1'b1;
        ev.ret_target_i  = 32'h8000_0104;
        tick();
        ev.call_valid_i = 1'b0;
        ev.ret_valid_i  = 1'b0;
        chk("sim_viol", ev.violation_o, 0);
        chk("sim_count", count, 1);
        tick();
        ret(32'h8000_0300);
        chk("sim_next_viol", ev.violation_o, 0);
        chk("sim_next_count", count, 0);
        tick();
        chk("sim_alarm", alarm, 0);

        // Bit 0 of the return target is ignored
        push(32'h8000_0500);
        ret(32'h8000_0501);
        chk("lsb_viol", ev.violation_o, 0);
        tick();

        // Checking disabled: mismatched return ignored
        push(32'h8000_0600);
        en = 1'b0;
        ret(32'h8000_0700);
        chk("dis_count", count, 1);
        chk("dis_viol", ev.violation_o, 0);
        tick();
        chk("dis_viol2", ev.violation_o, 0);
        chk("dis_alarm", alarm, 0);
        en = 1'b1;

        // flush_i during a CHECK mismatch suppresses the violation
        ret(32'h8000_0704);
        flush = 1'b1;
        #1;
        chk("fl_viol", ev.violation_o, 0);
        tick();
        flush = 1'b0;
        chk("fl_alarm", alarm, 0);
        chk("fl_ready", ev.ready_o, 0);
        // Restart the walk part way through
        tick();
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        flush_wait("restart");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
